// File: rtl/seven_segment_bcd_reader.sv
// Reads back a two-digit BCD value from a multiplexed active-low seven-segment bus.
// Each digit is debounced over STABLE_CNT matching samples before it is decoded and committed.
module seven_segment_bcd_reader #(
  parameter int STABLE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg,
  input  logic [1:0] dig_en,
  output logic [3:0] bcd_ones,
  output logic [3:0] bcd_tens,
  output logic       valid,
  output logic [6:0] bin,
  output logic       upd,
  output logic       code_err,
  output logic       sel_err
);

  localparam logic [3:0] STABLE = 4'(STABLE_CNT);

  // Returns {legal, value}; blank (7F) is legal and reads as zero.
  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    case (s)
      7'h01:   decode_seg = {1'b1, 4'd0};
      7'h4F:   decode_seg = {1'b1, 4'd1};
      7'h12:   decode_seg = {1'b1, 4'd2};
      7'h06:   decode_seg = {1'b1, 4'd3};
      7'h4C:   decode_seg = {1'b1, 4'd4};
      7'h24:   decode_seg = {1'b1, 4'd5};
      7'h20:   decode_seg = {1'b1, 4'd6};
      7'h0F:   decode_seg = {1'b1, 4'd7};
      7'h00:   decode_seg = {1'b1, 4'd8};
      7'h04:   decode_seg = {1'b1, 4'd9};
      7'h7F:   decode_seg = {1'b1, 4'd0};
      default: decode_seg = {1'b0, 4'd0};
    endcase
  endfunction

  // Index 0 is the ones digit, index 1 the tens digit.
  logic [1:0][6:0] cand_q, cand_d;
  logic [1:0][3:0] cnt_q, cnt_d;
  logic [1:0][3:0] bcd_q, bcd_d;
  logic [1:0]      ok_q, ok_d;
  logic [1:0][4:0] dec_s;
  logic [1:0]      take_s;
  logic            commit_q, commit_d;
  logic            valid_q, valid_d;
  logic [6:0]      bin_q, bin_d;
  logic            upd_q, upd_d;
  logic            code_err_q, code_err_d;
  logic            sel_err_q, sel_err_d;

  // Next-state logic for both digit filters, commit decode and the binary result.
  always_comb begin
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;
    ok_d       = ok_q;
    commit_d   = 1'b0;
    code_err_d = 1'b0;
    sel_err_d  = (dig_en == 2'b11);
    for (int i = 0; i < 2; i++) begin
      dec_s[i]  = decode_seg(cand_q[i]);
      take_s[i] = (dig_en[0] ^ dig_en[1]) & dig_en[i];
      if (take_s[i]) begin
        if ((cnt_q[i] == 4'd0) || (seg != cand_q[i])) begin
          cand_d[i] = seg;
          cnt_d[i]  = 4'd1;
        end else if (cnt_q[i] != STABLE) begin
          cnt_d[i] = cnt_q[i] + 4'd1;
          if (cnt_q[i] == (STABLE - 4'd1)) begin
            commit_d = 1'b1;
            if (dec_s[i][4]) begin
              bcd_d[i] = dec_s[i][3:0];
              ok_d[i]  = 1'b1;
            end else begin
              ok_d[i]    = 1'b0;
              code_err_d = 1'b1;
            end
          end else begin
            ok_d[i] = ok_q[i];
          end
        end else begin
          cnt_d[i] = cnt_q[i];
        end
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
    valid_d = ok_d[0] & ok_d[1];
    // bin follows the commit by one cycle so it always sees settled digits.
    upd_d = commit_q;
    if (commit_q) begin
      bin_d = ({3'b000, bcd_q[1]} * 7'd10) + {3'b000, bcd_q[0]};
    end else begin
      bin_d = bin_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q     <= {2{7'h7F}};
      cnt_q      <= '0;
      bcd_q      <= '0;
      ok_q       <= 2'b00;
      commit_q   <= 1'b0;
      valid_q    <= 1'b0;
      bin_q      <= 7'd0;
      upd_q      <= 1'b0;
      code_err_q <= 1'b0;
      sel_err_q  <= 1'b0;
    end else begin
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      bcd_q      <= bcd_d;
      ok_q       <= ok_d;
      commit_q   <= commit_d;
      valid_q    <= valid_d;
      bin_q      <= bin_d;
      upd_q      <= upd_d;
      code_err_q <= code_err_d;
      sel_err_q  <= sel_err_d;
    end
  end

  assign bcd_ones = bcd_q[0];
  assign bcd_tens = bcd_q[1];
  assign valid    = valid_q;
  assign bin      = bin_q;
  assign upd      = upd_q;
  assign code_err = code_err_q;
  assign sel_err  = sel_err_q;

endmodule

// File: tb/tb_seven_segment_bcd_reader.sv
// Self-checking bench: directed scenarios plus random traffic, compared every cycle
// against a run-length reference model of the display reader.
module tb_seven_segment_bcd_reader;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg;
  logic [1:0] dig_en;
  logic [3:0] bcd_ones, bcd_tens;
  logic       valid, upd, code_err, sel_err;
  logic [6:0] bin;

  int checks = 0;
  int failures = 0;

  seven_segment_bcd_reader #(.STABLE_CNT(S)) dut (
    .clk(clk), .rst(rst), .seg(seg), .dig_en(dig_en),
    .bcd_ones(bcd_ones), .bcd_tens(bcd_tens), .valid(valid),
    .bin(bin), .upd(upd), .code_err(code_err), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  logic [6:0] codes [10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
                             7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};

  // Reference model state
  int         m_run [2];
  logic [6:0] m_cand [2];
  int         m_bcd [2];
  bit         m_ok [2];
  bit         m_pend;
  int         e_bin;
  bit         e_upd, e_cerr, e_serr, e_valid;
  int         upd_cnt, cerr_cnt, serr_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lookup(input logic [6:0] s);
    if (s == 7'h7F) return 0;
    for (int k = 0; k < 10; k++) if (codes[k] == s) return k;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_cand[i] = 7'h7F; m_bcd[i] = 0; m_ok[i] = 0;
    end
    m_pend = 0; e_bin = 0; e_upd = 0; e_cerr = 0; e_serr = 0; e_valid = 0;
  endtask

  task automatic model_edge(input logic r, input logic [1:0] en, input logic [6:0] s);
    int d, v;
    if (r) begin
      model_reset();
      return;
    end
    e_upd = m_pend;
    if (m_pend) e_bin = m_bcd[1] * 10 + m_bcd[0];
    m_pend = 0;
    e_cerr = 0;
    e_serr = (en == 2'b11);
    if (en == 2'b01 || en == 2'b10) begin
      d = (en == 2'b01) ? 0 : 1;
      if (m_run[d] == 0 || s != m_cand[d]) begin
        m_cand[d] = s;
        m_run[d] = 1;
      end else if (m_run[d] < S) begin
        m_run[d]++;
        if (m_run[d] == S) begin
          m_pend = 1;
          v = lookup(m_cand[d]);
          if (v >= 0) begin
            m_bcd[d] = v; m_ok[d] = 1;
          end else begin
            m_ok[d] = 0; e_cerr = 1;
          end
        end
      end
    end
    e_valid = m_ok[0] && m_ok[1];
  endtask

  task automatic step(input logic r, input logic [1:0] en, input logic [6:0] s);
    rst = r; dig_en = en; seg = s;
    @(posedge clk);
    model_edge(r, en, s);
    #1;
    check("bcd_ones", 32'(bcd_ones), 32'(m_bcd[0]));
    check("bcd_tens", 32'(bcd_tens), 32'(m_bcd[1]));
    check("valid", 32'(valid), 32'(e_valid));
    check("bin", 32'(bin), 32'(e_bin));
    check("upd", 32'(upd), 32'(e_upd));
    check("code_err", 32'(code_err), 32'(e_cerr));
    check("sel_err", 32'(sel_err), 32'(e_serr));
    upd_cnt += int'(upd);
    cerr_cnt += int'(code_err);
    serr_cnt += int'(sel_err);
  endtask

  task automatic repeat_step(input int n, input logic [1:0] en, input logic [6:0] s);
    for (int k = 0; k < n; k++) step(1'b0, en, s);
  endtask

  logic [6:0] hold_seg [2];
  int sel;

  initial begin
    model_reset();
    rst = 1'b1; dig_en = 2'b00; seg = 7'h7F;
    step(1'b1, 2'b00, 7'h7F);
    step(1'b1, 2'b00, 7'h7F);
    check("reset_bin", 32'(bin), 32'd0);
    check("reset_valid", 32'(valid), 32'd0);

    // Legal two-digit read: 15
    upd_cnt = 0;
    repeat_step(S, 2'b01, 7'h24);
    check("read_ones", 32'(bcd_ones), 32'd5);
    repeat_step(S, 2'b10, 7'h4F);
    check("read_tens", 32'(bcd_tens), 32'd1);
    check("read_valid", 32'(valid), 32'd1);
    step(1'b0, 2'b00, 7'h7F);
    check("read_bin", 32'(bin), 32'd15);
    repeat_step(2, 2'b00, 7'h7F);
    check("read_upd_count", 32'(upd_cnt), 32'd2);

    // Glitch rejection
    upd_cnt = 0;
    repeat_step(3, 2'b01, 7'h06);
    repeat_step(4, 2'b01, 7'h12);
    repeat_step(2, 2'b00, 7'h7F);
    check("glitch_ones", 32'(bcd_ones), 32'd2);
    check("glitch_upd_count", 32'(upd_cnt), 32'd1);

    // Illegal pattern after a committed 5
    repeat_step(S, 2'b01, 7'h24);
    repeat_step(2, 2'b00, 7'h7F);
    upd_cnt = 0; cerr_cnt = 0;
    repeat_step(S, 2'b01, 7'h7E);
    repeat_step(2, 2'b00, 7'h7F);
    check("illegal_cerr_count", 32'(cerr_cnt), 32'd1);
    check("illegal_valid", 32'(valid), 32'd0);
    check("illegal_ones", 32'(bcd_ones), 32'd5);
    check("illegal_upd_count", 32'(upd_cnt), 32'd1);

    // Gaps between samples, then a collision cycle that must not disturb the run
    for (int k = 0; k < S; k++) begin
      step(1'b0, 2'b01, 7'h04);
      step(1'b0, 2'b00, 7'h7F);
    end
    check("gap_ones", 32'(bcd_ones), 32'd9);
    serr_cnt = 0; upd_cnt = 0;
    step(1'b0, 2'b11, 7'h12);
    repeat_step(3, 2'b01, 7'h04);
    repeat_step(2, 2'b00, 7'h7F);
    check("sel_err_count", 32'(serr_cnt), 32'd1);
    check("sel_no_recommit", 32'(upd_cnt), 32'd0);

    // Reset in the middle of a run
    repeat_step(3, 2'b01, 7'h20);
    step(1'b1, 2'b00, 7'h7F);
    check("midrst_ones", 32'(bcd_ones), 32'd0);
    check("midrst_tens", 32'(bcd_tens), 32'd0);
    check("midrst_bin", 32'(bin), 32'd0);
    repeat_step(S - 1, 2'b01, 7'h20);
    check("midrst_not_yet", 32'(bcd_ones), 32'd0);
    step(1'b0, 2'b01, 7'h20);
    check("midrst_commit", 32'(bcd_ones), 32'd6);

    // Leading-zero blank on the tens digit
    step(1'b1, 2'b00, 7'h7F);
    repeat_step(S, 2'b10, 7'h7F);
    repeat_step(S, 2'b01, 7'h04);
    step(1'b0, 2'b00, 7'h7F);
    check("blank_valid", 32'(valid), 32'd1);
    check("blank_tens", 32'(bcd_tens), 32'd0);
    check("blank_bin", 32'(bin), 32'd9);

    // Random traffic: held patterns per digit with occasional changes, illegal codes and resets
    hold_seg[0] = codes[3]; hold_seg[1] = codes[7];
    for (int n = 0; n < 3000; n++) begin
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(0, 7) == 0) begin
          if ($urandom_range(0, 9) == 0) hold_seg[d] = 7'($urandom_range(0, 127));
          else if ($urandom_range(0, 9) == 0) hold_seg[d] = 7'h7F;
          else hold_seg[d] = codes[$urandom_range(0, 9)];
        end
      end
      sel = $urandom_range(0, 9);
      if ($urandom_range(0, 299) == 0) step(1'b1, 2'b00, 7'h7F);
      else if (sel < 4) step(1'b0, 2'b01, hold_seg[0]);
      else if (sel < 8) step(1'b0, 2'b10, hold_seg[1]);
      else if (sel == 8) step(1'b0, 2'b00, 7'($urandom_range(0, 127)));
      else step(1'b0, 2'b11, 7'($urandom_range(0, 127)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
